// File: rtl/iilc_pkg.sv
// Shared definitions for the iter_integer_linear_calc round-robin arbiter:
// FSM encoding, default datapath width and the index-width helper.
package iilc_pkg;

    localparam int IILC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } iilc_state_e;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iilc_rr_pick.sv
// Combinational rotating-priority encoder: one-hot grant to the first
// asserted request at or after ptr (modulo NREQ), plus a found flag.
module iilc_rr_pick
    import iilc_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            found
);

    logic [IW-1:0] idx;

    // Walk from the farthest offset back to the pointer so the closest hit wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iilc_rr_arbiter.sv
// Round-robin scheduler sharing one iterative y = m*x + b calculator among NREQ clients.
// Optional watchdog compiled in with `define IILC_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | calculator released; accept the next requester by pointer
// RST     | calc_rst held high for RST_CYC cycles with operands latched
// WAIT    | wait for calc_valid (ignored in the first cycle)
// RESP    | one-cycle rsp_valid to the grantee; pointer advances
module iilc_rr_arbiter
    import iilc_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int W          = IILC_W,
    parameter int RST_CYC    = 2,
    parameter int TMO_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*W-1:0]         req_m,
    input  logic [NREQ*W-1:0]         req_x,
    input  logic [NREQ*W-1:0]         req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [W-1:0]              rsp_y,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [idx_w(NREQ)-1:0]    grant_id,
    output logic                      calc_rst,
    output logic [W-1:0]              calc_m,
    output logic [W-1:0]              calc_x,
    output logic [W-1:0]              calc_b,
    input  logic [W-1:0]              calc_y,
    input  logic                      calc_valid
);

    localparam int IW = idx_w(NREQ);
    localparam int RW = idx_w(RST_CYC + 1);

    if (NREQ < 2 || NREQ > 8 || RST_CYC < 1 || TMO_CYCLES < 1) begin : g_bad_param
        $error("iilc_rr_arbiter: parameter out of range");
    end

    iilc_state_e      state_q, state_d;
    logic [IW-1:0]    ptr_q;
    logic [RW-1:0]    rst_cnt_q;
    logic             wait_armed_q;
    logic [NREQ-1:0]  pick_gnt;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic             take;
    logic             done_ok;
    logic             done_tmo;

    iilc_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) pick_idx = IW'(i);
        end
    end

`ifdef IILC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          rsp_err_q;
`endif

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        done_ok  = 1'b0;
        done_tmo = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    take    = 1'b1;
                    state_d = ST_RST;
                end
            end
            ST_RST: begin
                if (rst_cnt_q == '0) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_armed_q && calc_valid) begin
                    done_ok = 1'b1;
                    state_d = ST_RESP;
                end
`ifdef IILC_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TMO_CYCLES)) begin
                    done_tmo = 1'b1;
                    state_d  = ST_RESP;
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            rst_cnt_q    <= '0;
            wait_armed_q <= 1'b0;
            grant_id     <= '0;
            calc_rst     <= 1'b1;
            calc_m       <= '0;
            calc_x       <= '0;
            calc_b       <= '0;
            rsp_y        <= '0;
        end else begin
            state_q      <= state_d;
            calc_rst     <= (state_d == ST_RST);
            wait_armed_q <= (state_q == ST_WAIT);
            if (take) begin
                grant_id  <= pick_idx;
                calc_m    <= req_m[int'(pick_idx)*W +: W];
                calc_x    <= req_x[int'(pick_idx)*W +: W];
                calc_b    <= req_b[int'(pick_idx)*W +: W];
                rst_cnt_q <= RW'(RST_CYC - 1);
            end else if (state_q == ST_RST && rst_cnt_q != '0) begin
                rst_cnt_q <= rst_cnt_q - 1'b1;
            end
            if (done_ok) begin
                rsp_y <= calc_y;
            end else if (done_tmo) begin
                rsp_y <= '0;
            end
            if (state_q == ST_RESP) begin
                ptr_q <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

`ifdef IILC_ARB_TIMEOUT_EN
    // Counter reads 0 in the first WAIT cycle, so the timeout lands TMO_CYCLES+1 cycles after entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state_q != ST_WAIT && state_d == ST_WAIT) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ST_WAIT && tmo_cnt_q != TW'(TMO_CYCLES)) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (done_ok) begin
                rsp_err_q <= 1'b0;
            end else if (done_tmo) begin
                rsp_err_q <= 1'b1;
            end
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign req_ready = (state_q == ST_IDLE && !rst) ? pick_gnt : '0;

    always_comb begin
        rsp_valid = '0;
        if (state_q == ST_RESP) rsp_valid[grant_id] = 1'b1;
    end

endmodule

// File: tb/tb_iilc_rr_arbiter.sv
// Scoreboard bench for iilc_rr_arbiter with a behavioural calculator model.
// Timeout scenario follows IILC_ARB_TIMEOUT_EN when the bench is built with it.
module tb_iilc_rr_arbiter;
    import iilc_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int TMO  = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*W-1:0]      req_m = '0;
    logic [NREQ*W-1:0]      req_x = '0;
    logic [NREQ*W-1:0]      req_b = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [W-1:0]           rsp_y;
    logic                   rsp_err;
    logic                   busy;
    logic [1:0]             grant_id;
    logic                   calc_rst;
    logic [W-1:0]           calc_m, calc_x, calc_b;
    logic [W-1:0]           calc_y = '0;
    logic                   calc_valid = 1'b0;
    logic                   stall = 1'b0;

    always #5 clk = ~clk;

    iilc_rr_arbiter #(.NREQ(NREQ), .W(W), .RST_CYC(2), .TMO_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_m      (req_m),
        .req_x      (req_x),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_y      (rsp_y),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .grant_id   (grant_id),
        .calc_rst   (calc_rst),
        .calc_m     (calc_m),
        .calc_x     (calc_x),
        .calc_b     (calc_b),
        .calc_y     (calc_y),
        .calc_valid (calc_valid)
    );

    // Calculator stand-in: result valid a few cycles after its reset drops.
    int calc_cnt = 0;
    always @(posedge clk) begin
        if (calc_rst) begin
            calc_cnt   <= 0;
            calc_valid <= 1'b0;
        end else if (!stall && !calc_valid) begin
            if (calc_cnt == 3) begin
                calc_valid <= 1'b1;
                calc_y     <= calc_m * calc_x + calc_b;
            end else begin
                calc_cnt <= calc_cnt + 1;
            end
        end
    end

    typedef struct {
        int         id;
        logic [31:0] y;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: counts pulses, tracks calc_rst runs and scores every response.
    int              cyc = 0;
    int              ready_cnt [NREQ];
    logic [NREQ-1:0] ready_last = '0;
    int              rsp_cnt = 0;
    int              rsp_cyc = 0;
    int              wait_cyc = 0;
    int              crst_run = 0;
    int              crst_last = 0;
    logic            crst_prev = 1'b1;
    exp_t            mon_e;
    logic [NREQ-1:0] mon_oh;

    always @(negedge clk) begin
        cyc++;
        ready_last = req_ready;
        if (rst) begin
            for (int i = 0; i < NREQ; i++) ready_cnt[i] = 0;
            crst_run  = 0;
            crst_prev = 1'b1;
        end else begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) ready_cnt[i]++;
            if (calc_rst) begin
                crst_run++;
            end else if (crst_prev) begin
                crst_last = crst_run;
                crst_run  = 0;
                wait_cyc  = cyc;
            end
            crst_prev = calc_rst;
            if (rsp_valid != '0) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b rsp_y=%0d with nothing expected", rsp_valid, rsp_y);
                end else begin
                    mon_e  = sb.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e.id] = 1'b1;
                    chk("rsp_valid_onehot", 64'(rsp_valid), 64'(mon_oh));
                    chk("rsp_y", 64'(rsp_y), 64'(mon_e.y));
                    chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~ready_last;
    endtask

    task automatic issue(input int id, input logic [31:0] m, input logic [31:0] x,
                         input logic [31:0] b, input logic [31:0] y, input logic err);
        exp_t e;
        req_m[id*W +: W] = m;
        req_x[id*W +: W] = x;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
        e.id = id; e.y = y; e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_quiet(input string nm, input int budget);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !busy && req_valid == '0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: still busy=%b pending=%0d after %0d cycles, required idle", nm, busy, sb.size(), budget);
        end
    endtask

    task automatic wait_accept(input int id);
        int n;
        n = 0;
        while (req_valid[id] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: requester %0d not accepted, required accept", id);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    int rsp_base;

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk("rst_calc_rst", 64'(calc_rst), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_rsp_y", 64'(rsp_y), 64'd0);
        chk("rst_calc_m", 64'(calc_m), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_calc_rst", 64'(calc_rst), 64'd0);

        // 1: single job, 11*16+10 = 186
        issue(0, 11, 16, 10, 186, 1'b0);
        wait_quiet("single", 200);
        chk("single_ready_cnt", 64'(ready_cnt[0]), 64'd1);
        chk("single_calc_rst_len", 64'(crst_last), 64'd2);
        chk("single_rsp_cnt", 64'(rsp_cnt), 64'd1);
        chk("single_rsp_y_hold", 64'(rsp_y), 64'd186);

        // 2: contention from pointer 0, 7*12+i
        do_reset();
        for (int i = 0; i < NREQ; i++) issue(i, 7, 12, i, 84 + i, 1'b0);
        wait_quiet("contention", 300);
        for (int i = 0; i < NREQ; i++) chk($sformatf("contention_ready_cnt%0d", i), 64'(ready_cnt[i]), 64'd1);

        // 3: rotation; after requester 1 the pointer sits at 2
        issue(1, 3, 5, 1, 16, 1'b0);
        wait_quiet("rot_first", 200);
        issue(2, 2, 9, 4, 22, 1'b0);
        issue(0, 10, 10, 0, 100, 1'b0);
        wait_quiet("rotation", 300);
        chk("rotation_ready_cnt2", 64'(ready_cnt[2]), 64'd2);
        chk("rotation_ready_cnt0", 64'(ready_cnt[0]), 64'd2);

        // 4: requester 3 withdraws while busy
        issue(0, 1, 2, 3, 5, 1'b0);
        wait_accept(0);
        tick();
        req_valid[3] = 1'b1;
        tick();
        req_valid[3] = 1'b0;
        wait_quiet("withdraw", 200);
        repeat (3) tick();
        chk("withdraw_ready_cnt3", 64'(ready_cnt[3]), 64'd1);
        chk("withdraw_busy", 64'(busy), 64'd0);

        // 5: reset during WAIT
        stall = 1'b1;
        issue(1, 6, 6, 6, 42, 1'b0);
        wait_accept(1);
        repeat (3) tick();
        chk("midjob_in_wait", 64'({busy, calc_rst}), 64'b10);
        rsp_base = rsp_cnt;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midjob_calc_rst", 64'(calc_rst), 64'd1);
        chk("midjob_busy", 64'(busy), 64'd0);
        chk("midjob_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midjob_grant_id", 64'(grant_id), 64'd0);
        chk("midjob_rsp_y", 64'(rsp_y), 64'd0);
        chk("midjob_calc_m", 64'(calc_m), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        stall = 1'b0;
        chk("midjob_no_rsp", 64'(rsp_cnt), 64'(rsp_base));
        issue(0, 4, 5, 6, 26, 1'b0);
        wait_quiet("after_reset", 200);

        // 6: calculator never answers
        stall = 1'b1;
        rsp_base = rsp_cnt;
`ifdef IILC_ARB_TIMEOUT_EN
        issue(2, 9, 9, 9, 0, 1'b1);
        wait_quiet("timeout", 200);
        chk("timeout_latency", 64'(rsp_cyc - wait_cyc), 64'd17);
        chk("timeout_rsp_cnt", 64'(rsp_cnt - rsp_base), 64'd1);
`else
        req_m[2*W +: W] = 9;
        req_x[2*W +: W] = 9;
        req_b[2*W +: W] = 9;
        req_valid[2] = 1'b1;
        repeat (1000) tick();
        chk("no_timeout_rsp_cnt", 64'(rsp_cnt), 64'(rsp_base));
        chk("no_timeout_busy", 64'(busy), 64'd1);
`endif
        do_reset();
        stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/iilc_rr_arbiter.md
Name: iilc_rr_arbiter

Overview:
- Round-robin scheduler that shares one iter_integer_linear_calc instance (y = m*x + b, iterative, multi-cycle) between NREQ requesters.
- Accepts one operand set per grant, restarts the calculator with those operands, waits for its valid, then returns y to the granted requester.
- Sits between client blocks and the single calculator instance; owns the calculator's rst, m, x and b inputs.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- W, 32: operand and result width; must match the calculator.
- RST_CYC, 2: number of cycles calc_rst is held high per job, minimum 1.
- TMO_CYCLES, 1024: watchdog limit in cycles. Used only when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request; held high with operands stable until accepted
- req_m  in  NREQ*W  flattened m operands; requester i uses bits [i*W +: W]
- req_x  in  NREQ*W  flattened x operands
- req_b  in  NREQ*W  flattened b operands
- req_ready  out  NREQ  one-hot, 1-cycle accept pulse
- rsp_valid  out  NREQ  one-hot, 1-cycle result pulse to the owning requester
- rsp_y  out  W  result; holds its value until the next response
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(NREQ)  index of the current or last grantee
- calc_rst  out  1  registered reset to the calculator
- calc_m  out  W  operand to the calculator, registered
- calc_x  out  W  operand to the calculator, registered
- calc_b  out  W  operand to the calculator, registered
- calc_y  in  W  calculator result
- calc_valid  in  1  calculator result-valid

Behaviour:
- Reset values: calc_rst=1, which holds the calculator in reset. All other outputs are 0. Round-robin pointer=0. FSM state=IDLE.
- Asynchronous reset mid-job: the job is abandoned with no response and the FSM returns to IDLE. The requester must re-request.
- FSM states:
  - IDLE: calc_rst=0. If any req_valid is high, pick the first asserted index at or after the pointer, modulo NREQ. Latch that requester's m, x and b into calc_m, calc_x and calc_b. Set grant_id. Pulse req_ready[grant] in the same cycle. Go to RST.
  - RST: calc_rst=1 for exactly RST_CYC cycles, then go to WAIT.
  - WAIT: calc_rst=0. calc_valid is ignored in the first WAIT cycle. From the second WAIT cycle on, calc_valid=1 causes calc_y to be latched into rsp_y and the FSM to go to RESP.
  - RESP: rsp_valid[grant_id]=1 for one cycle. rsp_err=0, or 1 if the watchdog fired. Pointer becomes (grant_id+1) mod NREQ. Go to IDLE.
- Latency:
  - Accept to response = RST_CYC + 1 + calculator time + 1 cycles.
  - Back-to-back grants: at most one idle cycle between RESP and the next accept.
- Fairness:
  - A requester whose req_valid is continuously asserted is granted within NREQ jobs.
  - A requester that drops req_valid before its req_ready pulse is never granted, and no error is raised.
- Simultaneous requests: resolved strictly by the rotating pointer. A requester that asserts req_valid during a job waits for IDLE.
- calc_m, calc_x and calc_b stay constant from accept until RESP.
- There is no arithmetic in this block, so no width growth. Overflow is the calculator's concern.

Optional Feature:
- Macro IILC_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TMO_CYCLES, the FSM goes to RESP with rsp_y=0 and rsp_err=1.
- Undefined: no counter. WAIT lasts indefinitely and rsp_err is tied to 0.

Decomposition:
- Shared package iilc_pkg holds:
  - the FSM state encoding (IDLE, RST, WAIT, RESP, 2 bits);
  - default W=32;
  - the idx_w($clog2) helper constant.
- One sub-module, iilc_rr_pick: a combinational rotating-priority encoder that takes req_valid and the pointer and produces a one-hot grant plus a found flag. It is reused elsewhere in the codebase.

Test Plan:
1. Single job: requester 0 sends m=11, x=16, b=10 → req_ready[0] pulses once, calc_rst is high for 2 cycles, rsp_valid[0] pulses once with rsp_y=186.
2. Contention: requesters 0..3 all assert simultaneously, with requester i using m=7, x=12, b=i → grants in order 0, 1, 2, 3 with rsp_y=84, 85, 86, 87. Each requester sees exactly one ready pulse and one rsp pulse.
3. Rotation: requester 1 completes, then requesters 0 and 2 assert together → requester 2 is granted first, then requester 0.
4. Withdrawal: requester 3 asserts req_valid for 1 cycle while busy, then drops it → requester 3 is never granted and busy returns low after the current job.
5. Mid-job reset: rst is asserted during WAIT → all outputs are at reset values immediately, there is no rsp_valid, and a new request from requester 0 completes normally.
6. With IILC_ARB_TIMEOUT_EN and TMO_CYCLES=16, calc_valid is forced to 0 → rsp_valid pulses 17 cycles after WAIT entry with rsp_err=1 and rsp_y=0. Without the macro, no response occurs within 1000 cycles.
